// File: rtl/ppe_pkg.sv
// Shared PE-network packet definitions: field positions, opcodes, node IDs
// and a packet builder used by every packet producer.
package ppe_pkg;

   localparam int PKT_W    = 30;
   localparam int DEST_MSB = 29;
   localparam int DEST_LSB = 26;
   localparam int OP_BIT   = 25;
   localparam int DATA_MSB = 24;
   localparam int DATA_LSB = 0;
   localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;

   localparam logic [3:0] IMEM_ID = 4'd10;

   typedef enum logic {
      OP_WEIGHT = 1'b0,
      OP_INPUT  = 1'b1
   } opcode_e;

   typedef logic [PKT_W-1:0] packet_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_REQ,
      ST_DONE
   } imem_state_e;

   function automatic packet_t make_packet(input logic [3:0]        dest,
                                           input opcode_e           op,
                                           input logic [DATA_W-1:0] data);
      packet_t p;
      p                    = '0;
      p[DEST_MSB:DEST_LSB] = dest;
      p[OP_BIT]            = op;
      p[DATA_MSB:DATA_LSB] = data;
      return p;
   endfunction

endpackage

// File: rtl/imem_row_store.sv
// Ifmap row storage: one synchronous write port, one combinational read port
// so the caller can register the row straight into its output packet.
module imem_row_store #(
   parameter int NUM_ROWS  = 25,
   parameter int ROW_WIDTH = 25,
   parameter int ADDR_W    = 5
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    waddr,
   input  logic [ROW_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]    raddr,
   output logic [ROW_WIDTH-1:0] rdata
);

   logic [ROW_WIDTH-1:0] mem [NUM_ROWS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Streams stored ifmap rows to a PE as INPUT packets, one row per PE request.
// Optional IMEM_ADDR_CHECK_EN: only requests addressed to IMEM_ID advance the stream.
module imem_responder
   import ppe_pkg::*;
#(
   parameter int         NUM_ROWS  = 25,
   parameter int         ROW_WIDTH = 25,
   parameter logic [3:0] PPE_ADDR  = 4'd0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_en,
   input  logic [4:0]           load_addr,
   input  logic [ROW_WIDTH-1:0] load_data,
   input  logic                 start,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [29:0]          req_packet,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [29:0]          rsp_packet,
   output logic                 busy,
   output logic                 done
`ifdef IMEM_ADDR_CHECK_EN
   ,
   output logic [7:0]           err_cnt
`endif
);

   localparam logic [4:0] LAST_ROW  = 5'(NUM_ROWS - 1);
   localparam logic [5:0] ROW_LIMIT = 6'(NUM_ROWS);

   imem_state_e          state_q, state_d;
   logic [4:0]           row_ptr_q, row_ptr_d;
   logic                 rsp_valid_q, rsp_valid_d;
   packet_t              rsp_packet_q, rsp_packet_d;
   logic                 req_ready_q, req_ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
`ifdef IMEM_ADDR_CHECK_EN
   logic [7:0]           err_cnt_q, err_cnt_d;
`endif

   logic                 row_we;
   logic [4:0]           rd_addr;
   logic [ROW_WIDTH-1:0] rd_data;
   logic [DATA_W-1:0]    row_ext;
   logic                 req_fire;
   logic                 req_dest_ok;
   logic                 unused_req_bits;

   // Rows may only change while no run is reading them.
   assign row_we  = load_en && (state_q == ST_IDLE || state_q == ST_DONE)
                    && ({1'b0, load_addr} < ROW_LIMIT);
   assign rd_addr = (state_q == ST_WAIT_REQ) ? row_ptr_q : 5'd0;
   assign row_ext = DATA_W'(rd_data);

   imem_row_store #(
      .NUM_ROWS  (NUM_ROWS),
      .ROW_WIDTH (ROW_WIDTH),
      .ADDR_W    (5)
   ) u_row_store (
      .clk   (clk),
      .we    (row_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign req_fire        = req_valid && req_ready_q;
   assign unused_req_bits = ^req_packet;
`ifdef IMEM_ADDR_CHECK_EN
   assign req_dest_ok = (req_packet[DEST_MSB:DEST_LSB] == IMEM_ID);
`else
   assign req_dest_ok = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      row_ptr_d    = row_ptr_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_packet_d = rsp_packet_q;
      req_ready_d  = req_ready_q;
      busy_d       = busy_q;
      done_d       = done_q;
`ifdef IMEM_ADDR_CHECK_EN
      err_cnt_d    = err_cnt_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_SEND;
               row_ptr_d    = 5'd0;
               rsp_valid_d  = 1'b1;
               rsp_packet_d = make_packet(PPE_ADDR, OP_INPUT, row_ext);
               busy_d       = 1'b1;
               done_d       = 1'b0;
            end
         end
         ST_SEND: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (row_ptr_q == LAST_ROW) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_WAIT_REQ;
                  row_ptr_d   = row_ptr_q + 5'd1;
                  req_ready_d = 1'b1;
               end
            end
         end
         ST_WAIT_REQ: begin
            if (req_fire) begin
               if (req_dest_ok) begin
                  state_d      = ST_SEND;
                  req_ready_d  = 1'b0;
                  rsp_valid_d  = 1'b1;
                  rsp_packet_d = make_packet(PPE_ADDR, OP_INPUT, row_ext);
               end
`ifdef IMEM_ADDR_CHECK_EN
               else if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         row_ptr_q    <= 5'd0;
         rsp_valid_q  <= 1'b0;
         rsp_packet_q <= '0;
         req_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
         err_cnt_q    <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         row_ptr_q    <= row_ptr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_packet_q <= rsp_packet_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef IMEM_ADDR_CHECK_EN
         err_cnt_q    <= err_cnt_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_packet = rsp_packet_q;
   assign busy       = busy_q;
   assign done       = done_q;
`ifdef IMEM_ADDR_CHECK_EN
   assign err_cnt    = err_cnt_q;
`endif

endmodule
